sdram_sample_streamer: RTL and testbench
========================================

Name: sdram_sample_streamer

Overview:
- Requester-side client of the SDRAM controller's Req/Ack/Busy user port.
- Capture mode: buffers incoming ADC samples in a small FIFO and writes them to consecutive SDRAM addresses.
- Readout mode: reads a stored block back and presents it on a valid/ready output stream.
- Sits between the ADC front end / host readout logic and the SDRAM controller.

Parameters:
- FIFO_LOG2, 4, log2 of capture FIFO depth (default 16 entries).
- DATA_W, 16, sample and SDRAM word width.
- ADDR_W, 22, SDRAM word address width.
- TIMEOUT_CYC, 1024, Ack watchdog limit in cycles (used only when the optional feature is compiled in).

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse that begins an operation; honoured only in IDLE.
- Mode  in  1  sampled with Start: 0 = capture, 1 = readout.
- BaseAddr  in  ADDR_W  first word address, sampled with Start.
- Length  in  ADDR_W  number of words, sampled with Start.
- SampleIn  in  DATA_W  ADC sample.
- SampleValid  in  1  SampleIn is valid this cycle.
- SampleOut  out  DATA_W  readout word.
- SampleOutValid  out  1  SampleOut is valid.
- SampleOutReady  in  1  downstream consumer accepts SampleOut.
- Active  out  1  high while not IDLE.
- Done  out  1  one-cycle pulse when an operation completes.
- Overflow  out  1  sticky: a capture sample was dropped.
- Err  out  1  sticky watchdog error.
- MemReq  out  1  to controller Req.
- MemWnR  out  1  to controller WnR.
- MemAddr  out  ADDR_W  to controller Address.
- MemWrData  out  DATA_W  to controller DataIn.
- MemRdData  in  DATA_W  from controller DataOut.
- MemRdValid  in  1  MemRdData is valid this cycle.
- MemBusy  in  1  controller Busy.
- MemAck  in  1  controller Ack.

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, counters 0.

State machine:
- IDLE, on Start:
  - Latch BaseAddr, Length, Mode.
  - Clear Overflow and Err.
  - Length = 0: pulse Done on the next cycle and stay in IDLE.
  - Otherwise go to CAP_WAIT (Mode = 0) or RD_REQ (Mode = 1).
  - Start outside IDLE is ignored.
- CAP_WAIT:
  - Once the FIFO is non-empty and MemBusy = 0: MemReq <= 1, MemWnR <= 1, MemWrData <= FIFO head, MemAddr <= current address. Go to CAP_REQ.
- CAP_REQ:
  - Hold MemReq, MemAddr and MemWrData stable until MemAck = 1.
  - On the edge where MemAck = 1: MemReq <= 0, pop FIFO, increment address, increment word count.
  - If count reaches Length, go to DONE; otherwise go to CAP_WAIT.
- RD_REQ:
  - When MemBusy = 0: MemReq <= 1, MemWnR <= 0, MemAddr <= current address.
  - Hold MemReq until MemAck, drop it on the MemAck edge, then go to RD_WAIT.
- RD_WAIT:
  - On MemRdValid: SampleOut <= MemRdData, SampleOutValid <= 1, go to RD_OUT.
- RD_OUT:
  - Hold SampleOut and SampleOutValid until SampleOutReady = 1.
  - Then SampleOutValid <= 0, increment address and count.
  - Go to DONE if count reaches Length, otherwise RD_REQ.
- DONE: Done = 1 for one cycle, then IDLE.
- Any unused state encoding: go to IDLE and set Err.

Request and address rules:
- At most one outstanding request. MemReq is never raised while MemBusy = 1.
- Address arithmetic is modulo 2^ADDR_W; BaseAddr + Length past 0x3FFFFF wraps to 0.

FIFO:
- Written whenever SampleValid = 1 and state is CAP_WAIT or CAP_REQ; SampleValid in other states is discarded without flagging.
- Full with SampleValid = 1: sample dropped, Overflow <= 1.
- Push and pop in the same cycle are legal, including when full; that push is not dropped.
- Accepted-sample count is not limited to Length. Samples left in the FIFO at DONE are flushed.

Latency: first MemReq is asserted 1 cycle after the first sample is written to an empty FIFO, provided MemBusy = 0.

Reset mid-operation: asserting Reset_n low asynchronously clears everything, including MemReq (the controller is reset alongside).

Optional Feature:
- Macro: SDRAM_ACK_TIMEOUT_EN.
- Defined:
  - A counter runs while MemReq = 1 or the state is RD_WAIT.
  - Reaching TIMEOUT_CYC without MemAck (or MemRdValid in RD_WAIT) sets Err, drops MemReq, and goes to DONE.
  - Done still pulses.
- Not defined: no counter; Err is set only by the illegal-state path, and the block waits indefinitely.

Test Plan:
- Capture, base 0x000100, length 4: samples 0xA001..0xA004 on consecutive cycles, controller Ack 1 cycle after Req, Busy 2 cycles → four writes to 0x100..0x103 with matching data, MemWnR = 1, one Done pulse, Overflow = 0.
- Overflow: hold MemBusy = 1, feed 20 samples with FIFO_LOG2 = 4 → 16 stored, Overflow = 1. Release Busy → the first 16 are written in order.
- Readout, base 0x3FFFFE, length 3: addresses 0x3FFFFE, 0x3FFFFF, 0x000000. With SampleOutReady held low 5 cycles on word 2 → SampleOut stable and no new MemReq until ready.
- Length 0 Start → Done on the next cycle, no MemReq ever asserted. Start pulsed while Active → ignored.
- Reset_n low mid-CAP_REQ → MemReq, Active, SampleOutValid = 0 immediately, without a clock edge. State IDLE after release.
- With SDRAM_ACK_TIMEOUT_EN: MemAck never asserted → Err = 1 after 1024 cycles of MemReq, MemReq dropped, Done pulses. Without the macro → MemReq stays high.

Source files
------------

// File: rtl/sdram_sample_streamer.sv
// ---------------------------------------------------------------------------
// sdram_sample_streamer
//
// Requester-side client of the SDRAM controller Req/Ack/Busy user port.
//   Capture mode (Mode=0): ADC samples go into a small FIFO and are written
//     one at a time to consecutive SDRAM word addresses.
//   Readout mode (Mode=1): a block of words is read back one at a time and
//     presented on a valid/ready output stream.
//
// Ports
//   Clk, Reset_n                  clock, asynchronous active-low reset
//   Start, Mode, BaseAddr, Length operation request (sampled in IDLE only)
//   SampleIn, SampleValid         ADC sample input
//   SampleOut, SampleOutValid,
//   SampleOutReady                readout stream
//   Active, Done, Overflow, Err   status (Overflow/Err sticky until next Start)
//   MemReq, MemWnR, MemAddr,
//   MemWrData                     request side of the controller port
//   MemRdData, MemRdValid,
//   MemBusy, MemAck               response side of the controller port
//
// Build option
//   SDRAM_ACK_TIMEOUT_EN : when defined, a watchdog aborts a request that has
//   waited TIMEOUT_CYC cycles for MemAck (or MemRdValid in RD_WAIT), sets Err
//   and finishes the operation through DONE. When undefined there is no
//   watchdog and the block waits indefinitely.
// ---------------------------------------------------------------------------
module sdram_sample_streamer #(
    parameter int FIFO_LOG2   = 4,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 22,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Mode,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [ADDR_W-1:0] Length,
    input  logic [DATA_W-1:0] SampleIn,
    input  logic              SampleValid,
    output logic [DATA_W-1:0] SampleOut,
    output logic              SampleOutValid,
    input  logic              SampleOutReady,
    output logic              Active,
    output logic              Done,
    output logic              Overflow,
    output logic              Err,
    output logic              MemReq,
    output logic              MemWnR,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWrData,
    input  logic [DATA_W-1:0] MemRdData,
    input  logic              MemRdValid,
    input  logic              MemBusy,
    input  logic              MemAck
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAP_WAIT = 3'd1,
        ST_CAP_REQ  = 3'd2,
        ST_RD_REQ   = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_OUT   = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam int DEPTH = 1 << FIFO_LOG2;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              wnr_q, wnr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] sout_q, sout_d;
    logic              sout_valid_q, sout_valid_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;

    // Capture FIFO. The head is read combinationally so that the first
    // request can go out one cycle after the first sample lands.
    logic [DATA_W-1:0]    fifo_mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_LOG2:0]   fifo_cnt_q;
    logic                 fifo_full, fifo_empty;
    logic                 cap_state, push, pop, flush;
    logic                 last_word;
    logic                 wd_fire;

    assign fifo_full  = (fifo_cnt_q == (FIFO_LOG2+1)'(DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign cap_state  = (state_q == ST_CAP_WAIT) || (state_q == ST_CAP_REQ);
    // A full FIFO still accepts a sample on the cycle it is popped.
    assign push       = SampleValid && cap_state && (!fifo_full || pop);
    assign last_word  = ((cnt_q + ADDR_W'(1)) == len_q);

`ifdef SDRAM_ACK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_waiting;

    assign wd_waiting = (req_q && !MemAck) || ((state_q == ST_RD_WAIT) && !MemRdValid);
    assign wd_fire    = wd_waiting && (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign wd_d       = wd_waiting ? (wd_q + WD_W'(1)) : '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_fire = 1'b0;
    // No watchdog in this build; the range guard only keeps the parameter
    // referenced so both builds share one parameter list.
    if (TIMEOUT_CYC < 1) begin : g_timeout_range_check
    end
`endif

    // Next-state / output logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        wnr_d        = wnr_q;
        mem_addr_d   = mem_addr_q;
        wr_data_d    = wr_data_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
        done_d       = 1'b0;
        ovf_d        = ovf_q;
        err_d        = err_q;
        pop          = 1'b0;
        flush        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                flush = 1'b1;
                if (Start) begin
                    addr_d = BaseAddr;
                    len_d  = Length;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    err_d  = 1'b0;
                    if (Length == '0) begin
                        done_d = 1'b1;
                    end else if (Mode) begin
                        state_d = ST_RD_REQ;
                    end else begin
                        state_d = ST_CAP_WAIT;
                    end
                end
            end
            ST_CAP_WAIT: begin
                if (!fifo_empty && !MemBusy) begin
                    req_d      = 1'b1;
                    wnr_d      = 1'b1;
                    wr_data_d  = fifo_mem[rd_ptr_q];
                    mem_addr_d = addr_q;
                    state_d    = ST_CAP_REQ;
                end
            end
            ST_CAP_REQ: begin
                if (MemAck) begin
                    req_d   = 1'b0;
                    pop     = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    cnt_d   = cnt_q + ADDR_W'(1);
                    state_d = last_word ? ST_DONE : ST_CAP_WAIT;
                end
            end
            ST_RD_REQ: begin
                if (req_q) begin
                    if (MemAck) begin
                        req_d = 1'b0;
                        // Data arriving together with Ack is taken directly.
                        if (MemRdValid) begin
                            sout_d       = MemRdData;
                            sout_valid_d = 1'b1;
                            state_d      = ST_RD_OUT;
                        end else begin
                            state_d = ST_RD_WAIT;
                        end
                    end
                end else if (!MemBusy) begin
                    req_d      = 1'b1;
                    wnr_d      = 1'b0;
                    mem_addr_d = addr_q;
                end
            end
            ST_RD_WAIT: begin
                if (MemRdValid) begin
                    sout_d       = MemRdData;
                    sout_valid_d = 1'b1;
                    state_d      = ST_RD_OUT;
                end
            end
            ST_RD_OUT: begin
                if (SampleOutReady) begin
                    sout_valid_d = 1'b0;
                    addr_d       = addr_q + ADDR_W'(1);
                    cnt_d        = cnt_q + ADDR_W'(1);
                    state_d      = last_word ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_DONE: begin
                flush   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                flush        = 1'b1;
                req_d        = 1'b0;
                sout_valid_d = 1'b0;
                err_d        = 1'b1;
                state_d      = ST_IDLE;
            end
        endcase

        // Watchdog abort wins over whatever the state wanted to do.
        if (wd_fire) begin
            err_d   = 1'b1;
            req_d   = 1'b0;
            state_d = ST_DONE;
        end

        if (SampleValid && cap_state && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end

        // DONE lasts exactly one cycle, so Done is high for exactly that cycle.
        if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            wnr_q        <= 1'b0;
            mem_addr_q   <= '0;
            wr_data_q    <= '0;
            sout_q       <= '0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            wnr_q        <= wnr_d;
            mem_addr_q   <= mem_addr_d;
            wr_data_q    <= wr_data_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
        end
    end

    // FIFO pointers; leftovers are discarded whenever the block is idle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + (FIFO_LOG2+1)'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - (FIFO_LOG2+1)'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= SampleIn;
        end
    end

    assign SampleOut      = sout_q;
    assign SampleOutValid = sout_valid_q;
    assign Active         = (state_q != ST_IDLE);
    assign Done           = done_q;
    assign Overflow       = ovf_q;
    assign Err            = err_q;
    assign MemReq         = req_q;
    assign MemWnR         = wnr_q;
    assign MemAddr        = mem_addr_q;
    assign MemWrData      = wr_data_q;

endmodule

// File: tb/tb_sdram_sample_streamer.sv
// ---------------------------------------------------------------------------
// tb_sdram_sample_streamer
//
// Directed bench for sdram_sample_streamer. A small controller model inside
// step() answers each request with Ack one cycle after Req, then holds Busy
// for busy_len cycles; reads return data = addr[15:0] ^ 16'h5A00 two cycles
// after Ack. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_sdram_sample_streamer;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic        Mode;
    logic [21:0] BaseAddr;
    logic [21:0] Length;
    logic [15:0] SampleIn;
    logic        SampleValid;
    logic [15:0] SampleOut;
    logic        SampleOutValid;
    logic        SampleOutReady;
    logic        Active;
    logic        Done;
    logic        Overflow;
    logic        Err;
    logic        MemReq;
    logic        MemWnR;
    logic [21:0] MemAddr;
    logic [15:0] MemWrData;
    logic [15:0] MemRdData;
    logic        MemRdValid;
    logic        MemBusy;
    logic        MemAck;

    sdram_sample_streamer dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .Start          (Start),
        .Mode           (Mode),
        .BaseAddr       (BaseAddr),
        .Length         (Length),
        .SampleIn       (SampleIn),
        .SampleValid    (SampleValid),
        .SampleOut      (SampleOut),
        .SampleOutValid (SampleOutValid),
        .SampleOutReady (SampleOutReady),
        .Active         (Active),
        .Done           (Done),
        .Overflow       (Overflow),
        .Err            (Err),
        .MemReq         (MemReq),
        .MemWnR         (MemWnR),
        .MemAddr        (MemAddr),
        .MemWrData      (MemWrData),
        .MemRdData      (MemRdData),
        .MemRdValid     (MemRdValid),
        .MemBusy        (MemBusy),
        .MemAck         (MemAck)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_assert = 0;
    int n_fail   = 0;

    // controller model state
    bit          ctl_en;
    bit          busy_force;
    bit          rd_ack;
    int          busy_len;
    int          busy_cnt;
    int          rd_delay;
    logic [21:0] rd_addr;

    // observation logs
    logic [21:0] tx_addr[$];
    logic        tx_wnr[$];
    logic [15:0] tx_data[$];
    logic [15:0] out_q[$];
    int          done_cnt;
    int          req_seen;
    int          busy_viol;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe the DUT #1 after the edge, then update the model.
    task automatic step();
        logic        hs;
        logic [15:0] hs_val;
        logic        prev_req;
        logic        prev_busy;
        hs        = SampleOutValid && SampleOutReady;
        hs_val    = SampleOut;
        prev_req  = MemReq;
        prev_busy = MemBusy;
        @(posedge Clk);
        #1;
        if (hs) out_q.push_back(hs_val);
        if (Done) done_cnt++;
        if (MemReq) req_seen++;
        if (MemReq && !prev_req && prev_busy) busy_viol++;

        MemRdValid = 1'b0;
        if (rd_delay > 0) begin
            rd_delay--;
            if (rd_delay == 0) begin
                MemRdValid = 1'b1;
                MemRdData  = rd_addr[15:0] ^ 16'h5A00;
            end
        end
        if (MemAck) begin
            MemAck   = 1'b0;
            busy_cnt = busy_len;
            if (rd_ack) rd_delay = 2;
        end else if (ctl_en && MemReq) begin
            MemAck  = 1'b1;
            rd_ack  = !MemWnR;
            rd_addr = MemAddr;
            tx_addr.push_back(MemAddr);
            tx_wnr.push_back(MemWnR);
            tx_data.push_back(MemWrData);
            $display("[%0t] tx %s addr=0x%06h wdata=0x%04h", $time,
                     MemWnR ? "WR" : "RD", MemAddr, MemWrData);
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        MemBusy = busy_force || (busy_cnt != 0);
    endtask

    task automatic clear_log();
        tx_addr.delete();
        tx_wnr.delete();
        tx_data.delete();
        out_q.delete();
        done_cnt  = 0;
        req_seen  = 0;
        busy_viol = 0;
    endtask

    task automatic model_reset();
        MemAck     = 1'b0;
        MemRdValid = 1'b0;
        MemRdData  = '0;
        busy_cnt   = 0;
        rd_delay   = 0;
        rd_ack     = 1'b0;
        busy_force = 1'b0;
        MemBusy    = 1'b0;
    endtask

    task automatic start_op(input logic m, input logic [21:0] base, input logic [21:0] len);
        Start    = 1'b1;
        Mode     = m;
        BaseAddr = base;
        Length   = len;
        step();
        Start = 1'b0;
    endtask

    task automatic run_to_idle(input int max_cyc);
        for (int k = 0; k < max_cyc && Active; k++) step();
    endtask

    initial begin
        int          hold;
        int          hold_bad;
        int          bad;
        int          req_cyc;
        logic [15:0] held_val;

        Reset_n        = 1'b0;
        Start          = 1'b0;
        Mode           = 1'b0;
        BaseAddr       = '0;
        Length         = '0;
        SampleIn       = '0;
        SampleValid    = 1'b0;
        SampleOutReady = 1'b1;
        ctl_en         = 1'b1;
        busy_len       = 2;
        model_reset();
        clear_log();

        // ---------------- reset state ----------------
        repeat (2) @(posedge Clk);
        #1;
        check("rst_memreq", MemReq, 0);
        check("rst_active", Active, 0);
        check("rst_done", Done, 0);
        check("rst_ovf", Overflow, 0);
        check("rst_err", Err, 0);
        check("rst_soutvalid", SampleOutValid, 0);
        check("rst_memaddr", MemAddr, 0);
        Reset_n = 1'b1;
        step();

        // ---------------- capture, base 0x100, len 4 ----------------
        clear_log();
        start_op(1'b0, 22'h000100, 22'd4);
        check("cap_active", Active, 1);
        for (int i = 0; i < 4; i++) begin
            SampleValid = 1'b1;
            SampleIn    = 16'hA001 + 16'(i);
            step();
            if (i == 0) check("cap_lat0_noreq", MemReq, 0);
            if (i == 1) check("cap_lat1_req", MemReq, 1);
        end
        SampleValid = 1'b0;
        run_to_idle(200);
        check("cap_idle", Active, 0);
        check("cap_ntx", tx_addr.size(), 4);
        bad = 0;
        for (int i = 0; i < tx_addr.size() && i < 4; i++) begin
            if (tx_addr[i] !== 22'h000100 + 22'(i)) bad++;
            if (tx_data[i] !== 16'hA001 + 16'(i)) bad++;
            if (tx_wnr[i] !== 1'b1) bad++;
        end
        check("cap_tx_content_errors", bad, 0);
        check("cap_done_pulses", done_cnt, 1);
        check("cap_ovf", Overflow, 0);
        check("cap_busy_viol", busy_viol, 0);

        // ---------------- overflow with Busy held ----------------
        clear_log();
        busy_force = 1'b1;
        MemBusy    = 1'b1;
        start_op(1'b0, 22'h000200, 22'd16);
        for (int i = 0; i < 20; i++) begin
            SampleValid = 1'b1;
            SampleIn    = 16'hB000 + 16'(i);
            step();
            if (i == 15) check("ovf_after16", Overflow, 0);
            if (i == 16) check("ovf_after17", Overflow, 1);
        end
        SampleValid = 1'b0;
        check("ovf_no_req_while_busy", req_seen, 0);
        busy_force = 1'b0;
        MemBusy    = (busy_cnt != 0);
        run_to_idle(600);
        check("ovf_idle", Active, 0);
        check("ovf_ntx", tx_addr.size(), 16);
        bad = 0;
        for (int i = 0; i < tx_addr.size() && i < 16; i++) begin
            if (tx_addr[i] !== 22'h000200 + 22'(i)) bad++;
            if (tx_data[i] !== 16'hB000 + 16'(i)) bad++;
        end
        check("ovf_tx_content_errors", bad, 0);
        check("ovf_sticky", Overflow, 1);
        check("ovf_done_pulses", done_cnt, 1);

        // ---------------- readout with address wrap ----------------
        clear_log();
        SampleOutReady = 1'b1;
        start_op(1'b1, 22'h3FFFFE, 22'd3);
        check("rd_ovf_cleared", Overflow, 0);
        hold     = 0;
        hold_bad = 0;
        held_val = '0;
        for (int k = 0; k < 300 && Active; k++) begin
            if (SampleOutValid && out_q.size() == 1 && hold < 5) begin
                SampleOutReady = 1'b0;
                if (hold == 0) held_val = SampleOut;
                else if (SampleOut !== held_val) hold_bad++;
                if (MemReq) hold_bad++;
                hold++;
            end else begin
                SampleOutReady = 1'b1;
            end
            step();
        end
        SampleOutReady = 1'b1;
        check("rd_idle", Active, 0);
        check("rd_hold_cycles", hold, 5);
        check("rd_hold_violations", hold_bad, 0);
        check("rd_ntx", tx_addr.size(), 3);
        if (tx_addr.size() == 3) begin
            check("rd_addr0", tx_addr[0], 22'h3FFFFE);
            check("rd_addr1", tx_addr[1], 22'h3FFFFF);
            check("rd_addr2", tx_addr[2], 22'h000000);
            check("rd_wnr0", tx_wnr[0], 0);
        end
        check("rd_nout", out_q.size(), 3);
        if (out_q.size() == 3) begin
            check("rd_out0", out_q[0], 16'hA5FE);
            check("rd_out1", out_q[1], 16'hA5FF);
            check("rd_out2", out_q[2], 16'h5A00);
        end
        check("rd_done_pulses", done_cnt, 1);
        check("rd_busy_viol", busy_viol, 0);

        // ---------------- length 0 ----------------
        clear_log();
        start_op(1'b0, 22'h000123, 22'd0);
        check("len0_done", Done, 1);
        check("len0_active", Active, 0);
        step();
        check("len0_done_drop", Done, 0);
        repeat (3) step();
        check("len0_no_req", req_seen, 0);

        // ---------------- Start while Active is ignored ----------------
        clear_log();
        start_op(1'b0, 22'h000300, 22'd2);
        start_op(1'b1, 22'h000999, 22'd5);
        for (int i = 0; i < 2; i++) begin
            SampleValid = 1'b1;
            SampleIn    = 16'hC000 + 16'(i);
            step();
        end
        SampleValid = 1'b0;
        run_to_idle(200);
        check("ign_ntx", tx_addr.size(), 2);
        if (tx_addr.size() == 2) begin
            check("ign_addr1", tx_addr[1], 22'h000301);
            check("ign_wnr1", tx_wnr[1], 1);
            check("ign_data1", tx_data[1], 16'hC001);
        end
        check("ign_done_pulses", done_cnt, 1);

        // ---------------- asynchronous reset mid CAP_REQ ----------------
        clear_log();
        ctl_en = 1'b0;
        start_op(1'b0, 22'h000400, 22'd4);
        SampleValid = 1'b1;
        SampleIn    = 16'hD000;
        step();
        SampleValid = 1'b0;
        for (int k = 0; k < 20 && !MemReq; k++) step();
        check("arst_req_before", MemReq, 1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("arst_memreq", MemReq, 0);
        check("arst_active", Active, 0);
        check("arst_soutvalid", SampleOutValid, 0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        model_reset();
        ctl_en = 1'b1;
        step();
        check("arst_idle_after", Active, 0);
        check("arst_req_after", MemReq, 0);

        // ---------------- Ack never arrives ----------------
        clear_log();
        ctl_en = 1'b0;
        start_op(1'b0, 22'h000500, 22'd1);
        SampleValid = 1'b1;
        SampleIn    = 16'hE000;
        step();
        SampleValid = 1'b0;
        for (int k = 0; k < 20 && !MemReq; k++) step();
        check("wd_req_up", MemReq, 1);
`ifdef SDRAM_ACK_TIMEOUT_EN
        req_cyc = 1;
        for (int k = 0; k < 1200 && MemReq; k++) begin
            step();
            if (MemReq) req_cyc++;
        end
        check("wd_req_cycles", req_cyc, 1024);
        check("wd_req_dropped", MemReq, 0);
        check("wd_err", Err, 1);
        check("wd_done", Done, 1);
        step();
        check("wd_idle", Active, 0);
`else
        req_cyc = 1;
        for (int k = 0; k < 1100; k++) begin
            step();
            if (MemReq) req_cyc++;
        end
        check("nowd_req_cycles", req_cyc, 1101);
        check("nowd_req_high", MemReq, 1);
        check("nowd_err", Err, 0);
        check("nowd_active", Active, 1);
`endif
        Reset_n = 1'b0;
        #2;
        Reset_n = 1'b1;
        model_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
